// File: rtl/alu_muldiv_if.sv
// Start/done handshake bundle between the execute stage and alu_muldiv.
// The master drives requests; the slave returns status and result.
interface alu_muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
);
    logic                     Start;
    logic                     Flush;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     Ready;
    logic                     Busy;
    logic                     Done;
    logic [DATA_WIDTH-1:0]    ALUResult;

    modport master (
        output Start, Flush, SrcA, SrcB, Operation,
        input  Ready, Busy, Done, ALUResult
    );

    modport slave (
        input  Start, Flush, SrcA, SrcB, Operation,
        output Ready, Busy, Done, ALUResult
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add / restoring division.
// Define ALU_MULDIV_FASTPATH_EN to resolve zero/div-by-zero/overflow early.
module alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input logic          clk,
    input logic          reset,
    alu_muldiv_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [W-1:0]             m_q, m_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic                     negq_q, negq_d;
    logic                     negr_q, negr_d;
    logic                     dz_q, dz_d;
    logic [W-1:0]             res_q, res_d;

    logic           is_div, sa_s, sb_s, a_neg, b_neg;
    logic [W-1:0]   ma, mb;
    logic [W:0]     mul_sum, div_r, div_rs;
    logic           div_ge;
    logic [2*W-1:0] mul_next, div_next, prod;
    logic [W-1:0]   quo, rem, result;

    assign is_div = bus.Operation[2];
    assign sa_s   = is_div ? ~bus.Operation[0]
                           : (bus.Operation[1] ^ bus.Operation[0]);
    assign sb_s   = is_div ? ~bus.Operation[0]
                           : (bus.Operation[1:0] == 2'b01);
    assign a_neg  = sa_s & bus.SrcA[W-1];
    assign b_neg  = sb_s & bus.SrcB[W-1];
    assign ma     = a_neg ? -bus.SrcA : bus.SrcA;
    assign mb     = b_neg ? -bus.SrcB : bus.SrcB;

    // Multiply: acc = {hi, multiplier}; add into hi, shift right.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]}
                    + (acc_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc = {remainder, quotient}; shift left, trial subtract.
    assign div_r    = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge   = div_r >= {1'b0, m_q};
    assign div_rs   = div_ge ? div_r - {1'b0, m_q} : div_r;
    assign div_next = {div_rs[W-1:0], acc_q[W-2:0], div_ge};

    assign prod = negq_q ? -acc_q : acc_q;
    assign quo  = dz_q ? {W{1'b1}}
                       : (negq_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
    assign rem  = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        result = rem;
        if (!op_q[2]) begin
            result = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end else if (!op_q[1]) begin
            result = quo;
        end
    end

`ifdef ALU_MULDIV_FASTPATH_EN
    logic fast_dz, fast_ovf, fast_mz;
    assign fast_dz  = is_div && (bus.SrcB == '0);
    assign fast_ovf = is_div && !bus.Operation[0]
                   && (bus.SrcA == {1'b1, {(W-1){1'b0}}})
                   && (bus.SrcB == {W{1'b1}});
    assign fast_mz  = !is_div && ((bus.SrcA == '0) || (bus.SrcB == '0));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        m_d     = m_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        res_d   = res_q;
        if (bus.Flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        op_d    = bus.Operation;
                        cnt_d   = '0;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        dz_d    = is_div && (bus.SrcB == '0);
                        m_d     = is_div ? mb : ma;
                        acc_d   = {{W{1'b0}}, is_div ? ma : mb};
                        state_d = RUN;
`ifdef ALU_MULDIV_FASTPATH_EN
                        if (fast_dz) begin
                            acc_d   = {ma, {W{1'b1}}};
                            state_d = FIX;
                        end else if (fast_ovf) begin
                            acc_d   = {{W{1'b0}}, bus.SrcA};
                            negq_d  = 1'b0;
                            negr_d  = 1'b0;
                            state_d = FIX;
                        end else if (fast_mz) begin
                            acc_d   = '0;
                            state_d = FIX;
                        end
`endif
                    end
                end
                RUN: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W-1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    res_d   = result;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
        end
    end

    assign bus.Ready     = (state_q == IDLE);
    assign bus.Busy      = (state_q == RUN) || (state_q == FIX);
    assign bus.Done      = (state_q == DONE);
    assign bus.ALUResult = res_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: arithmetic reference model plus a
// per-cycle compare of handshake, latency and result hold.
module tb_alu_muldiv;
    localparam int DW  = 32;
    localparam int LAT = DW + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_muldiv_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(3)) bus ();

    alu_muldiv #(.DATA_WIDTH(DW), .OPCODE_LENGTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                return p[63:32];
            end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Reference state: outstanding op, cycles since accept, held result.
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] exp_res = '0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        logic mready;
        mready = !pending;
        if (pending) cnt++;
        if (!reset) begin
            chk("ready", {31'd0, bus.Ready}, {31'd0, !pending});
            chk("busy", {31'd0, bus.Busy},
                {31'd0, pending && cnt >= 1 && cnt < LAT});
            chk("done", {31'd0, bus.Done}, {31'd0, pending && cnt == LAT});
            if (pending && cnt == LAT) begin
                chk("result", bus.ALUResult, exp_res);
                held    = exp_res;
                pending = 1'b0;
            end else begin
                chk("hold", bus.ALUResult, held);
            end
            if (pending && cnt > LAT + 6) begin
                n_err++;
                $display("FAIL timeout: no done after %0d cycles", cnt);
                pending = 1'b0;
            end
        end
        if (reset) begin
            pending = 1'b0;
            held    = '0;
        end else if (bus.Flush) begin
            pending = 1'b0;
        end else if (bus.Start && mready) begin
            pending = 1'b1;
            cnt     = 0;
            exp_res = model(bus.Operation, bus.SrcA, bus.SrcB);
        end
    end

    task automatic launch(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int k;
        k = 0;
        while (!bus.Ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        bus.Start = 1'b1;
        bus.Operation = op;
        bus.SrcA = a;
        bus.SrcB = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
        int k;
        chk("model", model(op, a, b), lit);
        launch(op, a, b);
        k = 0;
        while (!bus.Done && k < 60) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        bus.Operation = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.Ready}, 32'd1);
        chk("rst_result", bus.ALUResult, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op(3'd5, 32'd100, 32'd7, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 32'd2);
        run_op(3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op(3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op(3'd5, 32'd100, 32'd7, 32'd14);

        // Abort a DIVU ten cycles in; result must keep the prior value.
        launch(3'd5, 32'hFFFF_FFFF, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        chk("flush_ready", {31'd0, bus.Ready}, 32'd1);
        chk("flush_hold", bus.ALUResult, 32'd14);
        repeat (40) begin @(posedge clk); #1; end

        // Start together with Flush while idle is dropped.
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.Operation = 3'd0;
        bus.SrcA = 32'd3;
        bus.SrcB = 32'd3;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // A second Start during RUN must not disturb the running op.
        launch(3'd0, 32'd7, 32'hFFFF_FFFD);
        repeat (5) begin @(posedge clk); #1; end
        bus.Start = 1'b1;
        bus.Operation = 3'd4;
        bus.SrcA = 32'd50;
        bus.SrcB = 32'd5;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
        chk("run_start_result", bus.ALUResult, 32'hFFFF_FFEB);

        // Start held high: re-accepted on the first Ready cycle.
        bus.Start = 1'b1;
        bus.Operation = 3'd7;
        bus.SrcA = 32'd100;
        bus.SrcB = 32'd7;
        repeat (2 * (DW + 3) - 1) begin @(posedge clk); #1; end
        bus.Start = 1'b0;
        repeat (DW + 5) begin @(posedge clk); #1; end
        chk("b2b_result", bus.ALUResult, 32'd2);

        // Reset mid-RUN clears everything at that edge.
        launch(3'd1, 32'h8000_0000, 32'h8000_0000);
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_run_ready", {31'd0, bus.Ready}, 32'd1);
        chk("rst_run_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_run_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_run_result", bus.ALUResult, 32'd0);
        repeat (40) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
